// File: rtl/tx_link_ctrl_multilane.sv
// JESD204B transmit link layer for LANES lanes in lock-step: CGS, ILAS and DATA phases,
// local multiframe clock, SYNC~ error monitoring and a DATA-phase ramp test pattern.
module tx_link_ctrl_multilane #(
    parameter int LANES        = 2,
    parameter int F            = 1,
    parameter int K            = 32,
    parameter int ILA_MF       = 4,
    parameter int SYNC_ERR_CYC = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_sync_n,
    input  logic [8*LANES-1:0]   i_data,
    input  logic [LANES-1:0]     i_k,
    input  logic                 i_vld,
    input  logic                 i_test_en,
    input  logic [8*14-1:0]      i_cfg,
    output logic                 o_ready,
    output logic [8*LANES-1:0]   o_data,
    output logic [LANES-1:0]     o_k,
    output logic                 o_vld,
    output logic [1:0]           o_state,
    output logic                 o_lmfc,
    output logic                 o_sync_err
);

    localparam int FK    = F * K;
    localparam int CNT_W = (FK > 1) ? $clog2(FK) : 1;
    localparam int MF_W  = (ILA_MF > 1) ? $clog2(ILA_MF) : 1;
    localparam int LOW_W = $clog2(SYNC_ERR_CYC + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FK - 1);
    localparam logic [MF_W-1:0]  MF_LAST   = MF_W'(ILA_MF - 1);
    localparam logic [MF_W-1:0]  MF_CFG    = MF_W'(1);
    localparam logic [LOW_W-1:0] LOW_LIMIT = LOW_W'(SYNC_ERR_CYC);

    localparam logic [7:0] K28_0 = 8'h1C;
    localparam logic [7:0] K28_3 = 8'h7C;
    localparam logic [7:0] K28_4 = 8'h9C;
    localparam logic [7:0] K28_5 = 8'hBC;

    if (FK < 17 || FK > 256) begin : g_bad_frame_cfg
        $error("tx_link_ctrl_multilane: F*K must lie in 17..256");
    end

    typedef enum logic [1:0] {
        ST_CGS  = 2'd0,
        ST_ILAS = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t             state_q, state_d;
    state_t             state_out_q, state_out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [MF_W-1:0]    mf_q, mf_d;
    logic [7:0]         ramp_q, ramp_d;
    logic [LOW_W-1:0]   low_cnt_q, low_cnt_d;
    logic [LOW_W-1:0]   low_next;
    logic               sync_seen_q, sync_seen_d;
    logic               resync;

    logic [8*LANES-1:0] data_q, data_d;
    logic [LANES-1:0]   k_q, k_d;
    logic               vld_q, vld_d;
    logic               ready_q, ready_d;
    logic               lmfc_q, lmfc_d;
    logic               sync_err_q, sync_err_d;

    logic [7:0]         cfg_oct [16];
    logic [3:0]         cfg_idx;
    logic [7:0]         ilas_oct;
    logic               ilas_k;
    logic               ilas_lid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_CGS;
            cnt_q       <= '0;
            mf_q        <= '0;
            ramp_q      <= '0;
            low_cnt_q   <= '0;
            sync_seen_q <= 1'b0;
            state_out_q <= ST_CGS;
            data_q      <= {LANES{K28_5}};
            k_q         <= '1;
            vld_q       <= 1'b0;
            ready_q     <= 1'b0;
            lmfc_q      <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mf_q        <= mf_d;
            ramp_q      <= ramp_d;
            low_cnt_q   <= low_cnt_d;
            sync_seen_q <= sync_seen_d;
            state_out_q <= state_out_d;
            data_q      <= data_d;
            k_q         <= k_d;
            vld_q       <= vld_d;
            ready_q     <= ready_d;
            lmfc_q      <= lmfc_d;
            sync_err_q  <= sync_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        mf_d        = mf_q;
        ramp_d      = ramp_q;
        low_cnt_d   = '0;
        low_next    = low_cnt_q + 1'b1;
        sync_seen_d = 1'b0;
        sync_err_d  = 1'b0;
        resync      = 1'b0;
        case (state_q)
            ST_CGS: begin
                sync_seen_d = i_sync_n;
                mf_d        = '0;
                if (cnt_q == CNT_LAST && sync_seen_q) begin
                    state_d = ST_ILAS;
                end
            end
            ST_ILAS, ST_DATA: begin
                // A short SYNC~ low is only an error report; a long one forces re-sync.
                if (!i_sync_n) begin
                    low_cnt_d = low_next;
                    resync    = (low_next >= LOW_LIMIT);
                end else begin
                    sync_err_d = (low_cnt_q != '0);
                end
                if (resync) begin
                    state_d   = ST_CGS;
                    low_cnt_d = '0;
                end else if (state_q == ST_ILAS) begin
                    if (cnt_q == CNT_LAST) begin
                        mf_d = mf_q + 1'b1;
                        if (mf_q == MF_LAST) begin
                            state_d = ST_DATA;
                            ramp_d  = '0;
                        end
                    end
                end else if (i_test_en) begin
                    ramp_d = ramp_q + 1'b1;
                end
            end
            default: state_d = ST_CGS;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            cfg_oct[i] = (i < 14) ? i_cfg[8*i +: 8] : 8'h00;
        end
    end

    always_comb begin
        cfg_idx  = 4'(cnt_q - CNT_W'(2));
        ilas_oct = 8'(cnt_q);
        ilas_k   = 1'b0;
        ilas_lid = 1'b0;
        if (cnt_q == '0) begin
            ilas_oct = K28_0;
            ilas_k   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
            ilas_oct = K28_3;
            ilas_k   = 1'b1;
        end else if (mf_q == MF_CFG && cnt_q == CNT_W'(1)) begin
            ilas_oct = K28_4;
            ilas_k   = 1'b1;
        end else if (mf_q == MF_CFG && cnt_q <= CNT_W'(15)) begin
            ilas_oct = cfg_oct[cfg_idx];
            ilas_lid = (cfg_idx == 4'd2);
        end
    end

    // o_ready marks the cycles whose i_data is sampled in DATA, so it follows state_d.
    always_comb begin
        data_d      = {LANES{K28_5}};
        k_d         = '1;
        vld_d       = 1'b1;
        ready_d     = (state_d == ST_DATA);
        state_out_d = state_q;
        lmfc_d      = (cnt_q == '0);
        case (state_q)
            ST_ILAS: begin
                for (int n = 0; n < LANES; n++) begin
                    data_d[8*n +: 8] = ilas_lid ? 8'(n) : ilas_oct;
                    k_d[n]           = ilas_k;
                end
            end
            ST_DATA: begin
                if (i_test_en) begin
                    data_d = {LANES{ramp_q}};
                    k_d    = '0;
                end else if (i_vld) begin
                    data_d = i_data;
                    k_d    = i_k;
                end
            end
            default: ;
        endcase
    end

    assign o_ready    = ready_q;
    assign o_data     = data_q;
    assign o_k        = k_q;
    assign o_vld      = vld_q;
    assign o_state    = state_out_q;
    assign o_lmfc     = lmfc_q;
    assign o_sync_err = sync_err_q;

endmodule

// File: tb/tb_tx_link_ctrl_multilane.sv
// Directed bench for tx_link_ctrl_multilane (LANES=2, F=1, K=32): CGS, ILAS contents,
// DATA pass-through, ramp, SYNC~ error/re-sync handling and mid-operation reset.
module tb_tx_link_ctrl_multilane;

    localparam int LANES        = 2;
    localparam int F            = 1;
    localparam int K            = 32;
    localparam int FK           = F * K;
    localparam int ILA_MF       = 4;
    localparam int SYNC_ERR_CYC = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_sync_n;
    logic [15:0]       i_data;
    logic [1:0]        i_k;
    logic              i_vld;
    logic              i_test_en;
    logic [8*14-1:0]   i_cfg;
    logic              o_ready;
    logic [15:0]       o_data;
    logic [1:0]        o_k;
    logic              o_vld;
    logic [1:0]        o_state;
    logic              o_lmfc;
    logic              o_sync_err;

    int checks   = 0;
    int failures = 0;
    int exp_pos  = -1;

    always #5 clk = ~clk;

    tx_link_ctrl_multilane #(
        .LANES(LANES), .F(F), .K(K), .ILA_MF(ILA_MF), .SYNC_ERR_CYC(SYNC_ERR_CYC)
    ) dut (
        .clk(clk), .rst(rst), .i_sync_n(i_sync_n), .i_data(i_data), .i_k(i_k),
        .i_vld(i_vld), .i_test_en(i_test_en), .i_cfg(i_cfg), .o_ready(o_ready),
        .o_data(o_data), .o_k(o_k), .o_vld(o_vld), .o_state(o_state),
        .o_lmfc(o_lmfc), .o_sync_err(o_sync_err)
    );

    // exp_pos is the bench's own multiframe position of the octet currently on o_data.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) exp_pos = -1;
        else     exp_pos = (exp_pos + 1) % FK;
    endtask

    task automatic applyStimulus(input logic sync_n, input logic vld, input logic [15:0] data,
                                 input logic [1:0] k, input logic test_en);
        i_sync_n  = sync_n;
        i_vld     = vld;
        i_data    = data;
        i_k       = k;
        i_test_en = test_en;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [15:0] e_data, input logic [1:0] e_k,
                            input logic e_vld, input logic e_ready, input logic [1:0] e_state,
                            input logic e_err);
        checkOutput({tag, ".data"},  32'(o_data),     32'(e_data));
        checkOutput({tag, ".k"},     32'(o_k),        32'(e_k));
        checkOutput({tag, ".vld"},   32'(o_vld),      32'(e_vld));
        checkOutput({tag, ".ready"}, 32'(o_ready),    32'(e_ready));
        checkOutput({tag, ".state"}, 32'(o_state),    32'(e_state));
        checkOutput({tag, ".err"},   32'(o_sync_err), 32'(e_err));
        checkOutput({tag, ".lmfc"},  32'(o_lmfc),     32'(exp_pos == 0));
    endtask

    function automatic logic [8:0] ilasExp(input int m, input int j, input int lane);
        int idx;
        if (j == 0)                      return {1'b1, 8'h1C};
        if (j == FK - 1)                 return {1'b1, 8'h7C};
        if (m == 1 && j == 1)            return {1'b1, 8'h9C};
        if (m == 1 && j >= 2 && j <= 15) begin
            idx = j - 2;
            if (idx == 2) return {1'b0, 8'(lane)};
            return {1'b0, 8'hA0 + 8'(idx)};
        end
        return {1'b0, 8'(j)};
    endfunction

    task automatic checkIlas(input int m, input int j);
        logic [8:0] e0;
        logic [8:0] e1;
        e0 = ilasExp(m, j, 0);
        e1 = ilasExp(m, j, 1);
        checkAll($sformatf("ilas_m%0d_j%0d", m, j), {e1[7:0], e0[7:0]}, {e1[8], e0[8]},
                 1'b1, (m == ILA_MF - 1 && j == FK - 1), 2'd1, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0000, 2'b00, 1'b0);
        for (int i = 0; i < 14; i++) i_cfg[8*i +: 8] = 8'hA0 + 8'(i);
        tick();
        checkAll("reset", 16'hBCBC, 2'b11, 1'b0, 1'b0, 2'd0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 100; i++) begin
            tick();
            checkAll("cgs_hold", 16'hBCBC, 2'b11, 1'b1, 1'b0, 2'd0, 1'b0);
        end
        while (exp_pos != 10) begin
            tick();
            checkAll("cgs_align", 16'hBCBC, 2'b11, 1'b1, 1'b0, 2'd0, 1'b0);
        end

        // Released at output position 10: ILAS /R/ appears 22 octets later.
        applyStimulus(1'b1, 1'b0, 16'h0000, 2'b00, 1'b0);
        for (int i = 0; i < 21; i++) begin
            tick();
            checkAll("cgs_wait", 16'hBCBC, 2'b11, 1'b1, 1'b0, 2'd0, 1'b0);
        end
        for (int m = 0; m < ILA_MF; m++) begin
            for (int j = 0; j < FK; j++) begin
                tick();
                checkIlas(m, j);
            end
        end

        applyStimulus(1'b1, 1'b1, 16'hA53C, 2'b00, 1'b0);
        tick();
        checkAll("data_pass", 16'hA53C, 2'b00, 1'b1, 1'b1, 2'd2, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h1234, 2'b01, 1'b0);
        tick();
        checkAll("data_idle", 16'hBCBC, 2'b11, 1'b1, 1'b1, 2'd2, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h1C7C, 2'b10, 1'b0);
        tick();
        checkAll("data_kpass", 16'h1C7C, 2'b10, 1'b1, 1'b1, 2'd2, 1'b0);

        applyStimulus(1'b1, 1'b1, 16'hFFFF, 2'b11, 1'b1);
        for (int i = 0; i < 300; i++) begin
            logic [7:0] r;
            r = 8'(i % 256);
            tick();
            checkAll($sformatf("ramp_%0d", i), {r, r}, 2'b00, 1'b1, 1'b1, 2'd2, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 16'h0000, 2'b00, 1'b0);
        tick();
        checkAll("ramp_off", 16'hBCBC, 2'b11, 1'b1, 1'b1, 2'd2, 1'b0);

        for (int lows = 3; lows <= SYNC_ERR_CYC - 1; lows++) begin
            applyStimulus(1'b0, 1'b0, 16'h0000, 2'b00, 1'b0);
            for (int i = 0; i < lows; i++) begin
                tick();
                checkAll($sformatf("sync_low%0d", lows), 16'hBCBC, 2'b11, 1'b1, 1'b1, 2'd2, 1'b0);
            end
            applyStimulus(1'b1, 1'b0, 16'h0000, 2'b00, 1'b0);
            tick();
            checkAll($sformatf("sync_err%0d", lows), 16'hBCBC, 2'b11, 1'b1, 1'b1, 2'd2, 1'b1);
            tick();
            checkAll($sformatf("sync_clr%0d", lows), 16'hBCBC, 2'b11, 1'b1, 1'b1, 2'd2, 1'b0);
        end

        applyStimulus(1'b0, 1'b0, 16'h0000, 2'b00, 1'b0);
        for (int i = 0; i < SYNC_ERR_CYC - 1; i++) begin
            tick();
            checkAll("resync_low", 16'hBCBC, 2'b11, 1'b1, 1'b1, 2'd2, 1'b0);
        end
        tick();
        checkAll("resync_edge", 16'hBCBC, 2'b11, 1'b1, 1'b0, 2'd2, 1'b0);
        tick();
        checkAll("resync_cgs", 16'hBCBC, 2'b11, 1'b1, 1'b0, 2'd0, 1'b0);
        while (exp_pos != 5) begin
            tick();
            checkAll("cgs_again", 16'hBCBC, 2'b11, 1'b1, 1'b0, 2'd0, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 16'h0000, 2'b00, 1'b0);
        while (exp_pos != FK - 1) begin
            tick();
            checkAll("cgs_no_err", 16'hBCBC, 2'b11, 1'b1, 1'b0, 2'd0, 1'b0);
        end
        for (int idx = 0; idx <= 2 * FK + 5; idx++) begin
            tick();
            checkIlas(idx / FK, idx % FK);
        end

        rst = 1'b1;
        tick();
        checkAll("reset_mid", 16'hBCBC, 2'b11, 1'b0, 1'b0, 2'd0, 1'b0);
        rst = 1'b0;
        tick();
        checkAll("post_reset0", 16'hBCBC, 2'b11, 1'b1, 1'b0, 2'd0, 1'b0);
        tick();
        checkAll("post_reset1", 16'hBCBC, 2'b11, 1'b1, 1'b0, 2'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
